// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multi-cycle controller and the datapath.
// master = controller side, slave = datapath / instruction register side.
interface mc_control_fsm_if;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       zero;
   logic       mem_ready;
   logic       pc_write;
   logic       ir_write;
   logic       adr_src;
   logic       mem_read;
   logic       mem_write;
   logic       reg_write;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] result_src;
   logic [1:0] imm_src;
   logic [1:0] alu_op;
   logic       mem_timeout;
   logic [3:0] state_dbg;

   modport master (
      input  opcode, funct3, zero, mem_ready,
      output pc_write, ir_write, adr_src, mem_read, mem_write,
      output reg_write, alu_src_a, alu_src_b, result_src,
      output imm_src, alu_op, mem_timeout, state_dbg
   );

   modport slave (
      output opcode, funct3, zero, mem_ready,
      input  pc_write, ir_write, adr_src, mem_read, mem_write,
      input  reg_write, alu_src_a, alu_src_b, result_src,
      input  imm_src, alu_op, mem_timeout, state_dbg
   );
endinterface

// File: rtl/mc_control_fsm.sv
// RV32I multi-cycle main controller (fetch/decode/execute/mem/writeback).
// Define MC_ILLEGAL_TRAP_EN to trap unsupported opcodes instead of NOP.
module mc_control_fsm #(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic clk,
   input  logic rst,
   mc_control_fsm_if.master bus
`ifdef MC_ILLEGAL_TRAP_EN
   ,
   output logic illegal_instr
`endif
);

   typedef enum logic [3:0] {
      RESET_S  = 4'd0,
      FETCH    = 4'd1,
      DECODE   = 4'd2,
      MEMADR   = 4'd3,
      MEMREAD  = 4'd4,
      MEMWB    = 4'd5,
      MEMWRITE = 4'd6,
      EXEC_R   = 4'd7,
      EXEC_I   = 4'd8,
      ALUWB    = 4'd9,
      BRANCH   = 4'd10,
      JAL      = 4'd11
`ifdef MC_ILLEGAL_TRAP_EN
      ,
      TRAP     = 4'd12
`endif
   } state_t;

   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [3:0] MAX_C  = 4'(MEM_WAIT_MAX);

   state_t     state;
   state_t     state_n;
   logic [3:0] cnt;
   logic [3:0] cnt_inc;
   logic       timeout;
   logic       waiting;

   logic is_ld, is_st, is_r, is_i, is_br, is_jal;

   assign is_ld  = (bus.opcode == OP_LD);
   assign is_st  = (bus.opcode == OP_ST);
   assign is_r   = (bus.opcode == OP_R);
   assign is_i   = (bus.opcode == OP_I);
   assign is_br  = (bus.opcode == OP_BR);
   assign is_jal = (bus.opcode == OP_JAL);

   // A memory-facing state that stalls this cycle keeps the FSM in place.
   assign waiting = ((state == FETCH) || (state == MEMREAD) ||
                     (state == MEMWRITE)) && !bus.mem_ready;
   assign cnt_inc = (cnt == MAX_C) ? cnt : cnt + 4'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= RESET_S;
         cnt     <= 4'd0;
         timeout <= 1'b0;
      end else begin
         state <= state_n;
         if (waiting) begin
            cnt <= cnt_inc;
            if (cnt_inc == MAX_C)
               timeout <= 1'b1;
         end else begin
            cnt <= 4'd0;
         end
      end
   end

   always_comb begin
      state_n        = state;
      bus.pc_write   = 1'b0;
      bus.ir_write   = 1'b0;
      bus.adr_src    = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.reg_write  = 1'b0;
      bus.alu_src_a  = 2'b00;
      bus.alu_src_b  = 2'b00;
      bus.result_src = 2'b00;
      bus.alu_op     = 2'b00;
      unique case (state)
         RESET_S: state_n = FETCH;
         FETCH: begin
            bus.mem_read   = 1'b1;
            bus.alu_src_b  = 2'b10;
            bus.result_src = 2'b10;
            if (bus.mem_ready) begin
               bus.ir_write = 1'b1;
               bus.pc_write = 1'b1;
               state_n      = DECODE;
            end
         end
         DECODE: begin
            bus.alu_src_a = 2'b01;
            bus.alu_src_b = 2'b01;
            unique case (1'b1)
               is_ld || is_st: state_n = MEMADR;
               is_r:           state_n = EXEC_R;
               is_i:           state_n = EXEC_I;
               is_br:          state_n = BRANCH;
               is_jal:         state_n = JAL;
`ifdef MC_ILLEGAL_TRAP_EN
               default:        state_n = TRAP;
`else
               default:        state_n = FETCH;
`endif
            endcase
         end
         MEMADR: begin
            bus.alu_src_a = 2'b10;
            bus.alu_src_b = 2'b01;
            state_n       = is_ld ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            bus.mem_read = 1'b1;
            bus.adr_src  = 1'b1;
            if (bus.mem_ready)
               state_n = MEMWB;
         end
         MEMWB: begin
            bus.result_src = 2'b01;
            bus.reg_write  = 1'b1;
            state_n        = FETCH;
         end
         MEMWRITE: begin
            bus.adr_src   = 1'b1;
            bus.mem_write = 1'b1;
            if (bus.mem_ready)
               state_n = FETCH;
         end
         EXEC_R: begin
            bus.alu_src_a = 2'b10;
            bus.alu_op    = 2'b10;
            state_n       = ALUWB;
         end
         EXEC_I: begin
            bus.alu_src_a = 2'b10;
            bus.alu_src_b = 2'b01;
            bus.alu_op    = 2'b10;
            state_n       = ALUWB;
         end
         ALUWB: begin
            bus.reg_write = 1'b1;
            state_n       = FETCH;
         end
         BRANCH: begin
            bus.alu_src_a = 2'b10;
            bus.alu_op    = 2'b01;
            bus.pc_write  = ((bus.funct3 == 3'b000) && bus.zero) ||
                            ((bus.funct3 == 3'b001) && !bus.zero);
            state_n       = FETCH;
         end
         JAL: begin
            bus.alu_src_a = 2'b01;
            bus.alu_src_b = 2'b10;
            bus.pc_write  = 1'b1;
            state_n       = ALUWB;
         end
`ifdef MC_ILLEGAL_TRAP_EN
         TRAP: state_n = TRAP;
`endif
         default: state_n = RESET_S;
      endcase
   end

   always_comb begin
      bus.imm_src = 2'b00;
      unique case (1'b1)
         is_st:   bus.imm_src = 2'b01;
         is_br:   bus.imm_src = 2'b10;
         is_jal:  bus.imm_src = 2'b11;
         default: bus.imm_src = 2'b00;
      endcase
   end

   assign bus.mem_timeout = timeout;
   assign bus.state_dbg   = state;

`ifdef MC_ILLEGAL_TRAP_EN
   assign illegal_instr = (state == TRAP);
`endif

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle main controller for the RV32I core.
- Sequences the shared ALU, instruction/data memory port, register file and PC through fetch/decode/execute/memory/writeback states.
- Issues `alu_op` to the downstream ALU decoder, which turns `alu_op` plus `funct3`/`funct7_5` into `alu_ctrl`.
- Sits in the control unit between the instruction register and the datapath muxes/enables.

Parameters:
- MEM_WAIT_MAX, 15, maximum cycles a memory state waits for `mem_ready` before the timeout flag is raised (4-bit counter range).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  instruction register bits [6:0]
- funct3  in  3  instruction register bits [14:12]
- zero  in  1  ALU zero flag from the compare in BRANCH
- mem_ready  in  1  memory port completed the current access this cycle
- pc_write  out  1  PC register load enable
- ir_write  out  1  instruction register load enable (also latches old PC)
- adr_src  out  1  memory address: 0 = PC, 1 = ALU out register
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  register file write enable
- alu_src_a  out  2  00 = PC, 01 = old PC, 10 = rs1
- alu_src_b  out  2  00 = rs2, 01 = immediate, 10 = constant 4
- result_src  out  2  00 = ALU out register, 01 = memory data, 10 = ALU result
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J; combinational from `opcode`
- alu_op  out  2  00 = add, 01 = subtract/compare, 10 = funct-decoded
- mem_timeout  out  1  sticky: a memory wait exceeded MEM_WAIT_MAX
- state_dbg  out  4  current state encoding

Behaviour:
- Moore FSM with a Mealy qualification on `mem_ready`. Every output not listed for a state is 0.
- State encoding: RESET_S = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMREAD = 4, MEMWB = 5, MEMWRITE = 6, EXEC_R = 7, EXEC_I = 8, ALUWB = 9, BRANCH = 10, JAL = 11, TRAP = 12.
- Reset (async, rst = 1):
  - state = RESET_S, wait counter = 0, `mem_timeout` = 0.
  - All outputs 0 except `imm_src`, which follows `opcode`.
  - RESET_S holds one cycle after deassertion, then goes to FETCH.
  - Reset asserted mid-instruction aborts it immediately; no partial write is issued afterwards.
- FETCH:
  - Outputs: `mem_read` = 1, `adr_src` = 0, `alu_src_a` = 00, `alu_src_b` = 10, `alu_op` = 00, `result_src` = 10.
  - Holds while `mem_ready` = 0.
  - In the cycle `mem_ready` = 1, `ir_write` = 1 and `pc_write` = 1, then go to DECODE.
- DECODE:
  - Outputs: `alu_src_a` = 01, `alu_src_b` = 01, `alu_op` = 00 (branch target precompute).
  - Next state by `opcode`:
    - 0000011 (load) or 0100011 (store) -> MEMADR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - anything else -> FETCH (treated as NOP; see Optional Feature)
- MEMADR: `alu_src_a` = 10, `alu_src_b` = 01, `alu_op` = 00. Go to MEMREAD if `opcode` = 0000011, else MEMWRITE.
- MEMREAD:
  - Outputs: `mem_read` = 1, `adr_src` = 1.
  - Holds until `mem_ready` = 1, then goes to MEMWB.
- MEMWB: `result_src` = 01, `reg_write` = 1, then go to FETCH.
- MEMWRITE:
  - Outputs: `adr_src` = 1.
  - `mem_write` = 1 every cycle in this state (held level until acceptance).
  - Goes to FETCH on `mem_ready` = 1.
- EXEC_R: `alu_src_a` = 10, `alu_src_b` = 00, `alu_op` = 10, then go to ALUWB.
- EXEC_I: `alu_src_a` = 10, `alu_src_b` = 01, `alu_op` = 10, then go to ALUWB.
- ALUWB: `result_src` = 00, `reg_write` = 1, then go to FETCH.
- BRANCH:
  - Outputs: `alu_src_a` = 10, `alu_src_b` = 00, `alu_op` = 01, `result_src` = 00.
  - `pc_write` = `zero` when `funct3` = 000 and `~zero` when `funct3` = 001; 0 for any other `funct3`.
  - Then go to FETCH.
- JAL:
  - First cycle: `alu_src_a` = 01, `alu_src_b` = 10, `alu_op` = 00, `result_src` = 00, `pc_write` = 1.
  - Then go to ALUWB, which writes rd = old PC + 4.
- Memory wait counter:
  - Increments each cycle in FETCH/MEMREAD/MEMWRITE while `mem_ready` = 0.
  - Clears on any state change.
  - When it reaches MEM_WAIT_MAX, `mem_timeout` sets (sticky until reset); the FSM keeps waiting.
  - The counter saturates and does not wrap.
- `mem_ready` outside FETCH/MEMREAD/MEMWRITE is ignored.
- `state_dbg` = current state; its reset value is 0.

Optional Feature:
- Macro `MC_ILLEGAL_TRAP_EN`.
- Defined:
  - An unsupported opcode in DECODE goes to TRAP.
  - TRAP holds all enables at 0 and is left only by reset.
  - An extra output port `illegal_instr` (1 bit) is 1 in TRAP and 0 otherwise.
- Undefined: an unsupported opcode returns to FETCH (NOP); the TRAP state and `illegal_instr` port do not exist.

Test Plan:
- Reset: rst = 1 mid-MEMWRITE -> all enables 0 immediately, `state_dbg` = 0; after release, 1 cycle in RESET_S then FETCH.
- R-type, `mem_ready` = 1 always, `opcode` = 0110011 -> states 1, 2, 7, 9, 1.
  - `alu_op` = 10 in EXEC_R; `reg_write` = 1 only in ALUWB; total 4 cycles.
- Load with `mem_ready` low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles, then MEMWB with `result_src` = 01 and `reg_write` = 1.
  - Store: `mem_write` stays high through the whole wait.
- Branch: `funct3` = 000 with `zero` = 1 -> `pc_write` = 1 in BRANCH; `zero` = 0 -> `pc_write` = 0.
  - `funct3` = 001 inverts both results.
- Timeout: `mem_ready` = 0 for 20 cycles in FETCH -> `mem_timeout` rises on the 15th wait cycle and stays 1 after `mem_ready` returns.
- `opcode` = 0110111 -> DECODE then FETCH with no writes.
  - With `MC_ILLEGAL_TRAP_EN` defined: goes to TRAP, `illegal_instr` = 1, and no further `mem_read` until reset.
